// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: state codes,
// PC mux select codes and a small redirect helper.
package fetch_ctrl_pkg;

  // Controller states (legacy-compatible constant encoding)
  localparam logic [2:0] BOOT  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] HOLD  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  // PC source select codes seen by the IF mux
  localparam logic PC_SEL_SEQ   = 1'b0;
  localparam logic PC_SEL_REDIR = 1'b1;

  // A control-flow change resolved in ID this cycle
  function automatic logic is_redirect(input logic branch, input logic jump);
    return branch | jump;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the fetch controller's ID-side, memory-side and PC-control
// signals. The master side is the controller; the slave side is the
// surrounding pipeline / memory.
interface fetch_ctrl_if;

  logic        branch;
  logic        jump;
  logic [31:0] jump_addr;
  logic        stall;
  logic        imem_ack;

  logic        imem_req;
  logic        pc_write;
  logic        pc_sel;
  logic [31:0] redirect_addr;
  logic        ifid_write;
  logic        if_flush;
  logic        fetch_err;

  modport master (
    input  branch, jump, jump_addr, stall, imem_ack,
    output imem_req, pc_write, pc_sel, redirect_addr, ifid_write, if_flush, fetch_err
  );

  modport slave (
    output branch, jump, jump_addr, stall, imem_ack,
    input  imem_req, pc_write, pc_sel, redirect_addr, ifid_write, if_flush, fetch_err
  );

endinterface

// File: rtl/fetch_ctrl_watchdog.sv
// Fetch watchdog: counts cycles a request waits without an acknowledge and
// raises a sticky error once the wait reaches TIMEOUT. hit is the
// combinational "this wait cycle brings the count to TIMEOUT" strobe that the
// controller uses to enter its error state on the same edge the error sets.
module fetch_watchdog #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic ack,
  output logic hit,
  output logic fetch_err
);

  localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAXV   = {CNT_W{1'b1}};
  localparam bit               ENABLE = (TIMEOUT != 0);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc;
  logic             waiting;
  logic             err_r;

  assign waiting   = req & ~ack;
  assign cnt_inc   = cnt_r + ONE;
  assign hit       = ENABLE && waiting && (cnt_inc == LIMIT);
  assign fetch_err = err_r;

  // Wait counter: clears on ack or idle request, saturates when disabled
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (!waiting) begin
      cnt_r <= '0;
    end else if (cnt_r != MAXV) begin
      cnt_r <= cnt_inc;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (hit) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller. Runs the req/ack handshake with a
// variable-latency instruction memory, drives the PC enable/select and the
// IF/ID write/flush, holds a redirect that arrives while a fetch is in flight
// and applies it when the memory answers, and parks in ERR if a fetch hangs.
// PC-control outputs are Mealy: they react to imem_ack in the same cycle so
// a zero-wait memory sustains one instruction per cycle.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input logic          clk,
  input logic          reset,
  fetch_ctrl_if.master bus
);

  logic [2:0]  state_r;
  logic [2:0]  state_nxt;
  logic [2:0]  state_d;
  logic        pending_r;
  logic        pending_nxt;
  logic        pending_d;
  logic [31:0] target_r;
  logic [31:0] target_nxt;

  logic        redirect;
  logic        req;
  logic        pc_write;
  logic        pc_sel;
  logic        ifid_write;
  logic        if_flush;
  logic [31:0] redirect_addr;
  logic        wd_hit;
  logic        wd_err;

  assign redirect = is_redirect(bus.branch, bus.jump);

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .ack       (bus.imem_ack),
    .hit       (wd_hit),
    .fetch_err (wd_err)
  );

  // Next-state and per-cycle PC/IF control decode
  always_comb begin
    state_nxt   = state_r;
    pending_nxt = pending_r;
    target_nxt  = target_r;
    req         = 1'b0;
    pc_write    = 1'b0;
    pc_sel      = PC_SEL_SEQ;
    ifid_write  = 1'b0;
    if_flush    = 1'b0;
    case (state_r)
      BOOT: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        req = 1'b1;
        if (bus.imem_ack) begin
          if (redirect) begin
            // fetched word is wrong-path: drop it and take the target now
            if_flush = 1'b1;
            pc_write = 1'b1;
            pc_sel   = PC_SEL_REDIR;
          end else if (bus.stall) begin
            // discard; the same PC is fetched again once the stall clears
            state_nxt = HOLD;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end else if (redirect) begin
          // request must stay up until ack, so remember where to go
          if_flush    = 1'b1;
          target_nxt  = bus.jump_addr;
          pending_nxt = 1'b1;
          state_nxt   = DRAIN;
        end else begin
          state_nxt = FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          if_flush  = 1'b1;
          pc_write  = 1'b1;
          pc_sel    = PC_SEL_REDIR;
          state_nxt = FETCH;
        end else if (!bus.stall) begin
          state_nxt = FETCH;
        end else begin
          state_nxt = HOLD;
        end
      end
      DRAIN: begin
        req = 1'b1;
        if (bus.imem_ack) begin
          // stale response is dropped; the held target is applied even under stall
          if_flush    = 1'b1;
          pc_write    = 1'b1;
          pc_sel      = PC_SEL_REDIR;
          pending_nxt = 1'b0;
          state_nxt   = FETCH;
        end else if (redirect) begin
          if_flush   = 1'b1;
          target_nxt = bus.jump_addr;
        end else begin
          state_nxt = DRAIN;
        end
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: begin
        state_nxt   = BOOT;
        pending_nxt = 1'b0;
      end
    endcase

    if (state_r == BOOT || state_r == ERR) begin
      redirect_addr = 32'h0000_0000;
    end else if (pending_r) begin
      redirect_addr = target_r;
    end else begin
      redirect_addr = bus.jump_addr;
    end
  end

  // A hung fetch overrides any other transition
  assign state_d   = wd_hit ? ERR  : state_nxt;
  assign pending_d = wd_hit ? 1'b0 : pending_nxt;

  // State, pending-redirect flag and held target registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= BOOT;
      pending_r <= 1'b0;
      target_r  <= 32'h0000_0000;
    end else begin
      state_r   <= state_d;
      pending_r <= pending_d;
      target_r  <= target_nxt;
    end
  end

  assign bus.imem_req      = req;
  assign bus.pc_write      = pc_write;
  assign bus.pc_sel        = pc_sel;
  assign bus.redirect_addr = redirect_addr;
  assign bus.ifid_write    = ifid_write;
  assign bus.if_flush      = if_flush;
  assign bus.fetch_err     = wd_err;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations followed
// by randomized traffic, all outputs compared every cycle against a
// behavioural model of the fetch rules.
module tb_fetch_ctrl;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .TIMEOUT (TO),
    .CNT_W   (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  bit          m_valid = 1'b0;
  bit          m_boot, m_hold, m_pend, m_dead;
  int          m_wait;
  logic [31:0] m_tgt;

  // expected outputs for the current cycle
  logic        e_req, e_pcw, e_sel, e_ifid, e_fl, e_err;
  logic [31:0] e_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // What the outputs must be, from the model state and this cycle's inputs
  task automatic predict();
    logic redir;
    redir  = bus.branch | bus.jump;
    e_req  = 1'b0; e_pcw = 1'b0; e_sel = 1'b0; e_ifid = 1'b0; e_fl = 1'b0;
    e_err  = m_dead;
    if (m_dead || m_boot) begin
      // nothing moves
    end else if (m_hold) begin
      if (redir) begin e_fl = 1'b1; e_pcw = 1'b1; e_sel = 1'b1; end
    end else if (m_pend) begin
      e_req = 1'b1;
      if (bus.imem_ack) begin e_fl = 1'b1; e_pcw = 1'b1; e_sel = 1'b1; end
      else if (redir) e_fl = 1'b1;
    end else begin
      e_req = 1'b1;
      if (bus.imem_ack) begin
        if (redir) begin e_fl = 1'b1; e_pcw = 1'b1; e_sel = 1'b1; end
        else if (!bus.stall) begin e_pcw = 1'b1; e_ifid = 1'b1; end
      end else if (redir) e_fl = 1'b1;
    end
    if (m_dead || m_boot) e_addr = 32'h0;
    else if (m_pend) e_addr = m_tgt;
    else e_addr = bus.jump_addr;
  endtask

  task automatic compare_all();
    predict();
    chk("imem_req", bus.imem_req, e_req);
    chk("pc_write", bus.pc_write, e_pcw);
    chk("pc_sel", bus.pc_sel, e_sel);
    chk("ifid_write", bus.ifid_write, e_ifid);
    chk("if_flush", bus.if_flush, e_fl);
    chk("fetch_err", bus.fetch_err, e_err);
    chk("redirect_addr", bus.redirect_addr, e_addr);
  endtask

  task automatic drive(input logic r, input logic br, input logic jp,
                       input logic [31:0] ja, input logic st, input logic ak);
    @(negedge clk);
    reset         = r;
    bus.branch    = br;
    bus.jump      = jp;
    bus.jump_addr = ja;
    bus.stall     = st;
    bus.imem_ack  = ak;
    #2;
    if (m_valid) compare_all();
  endtask

  // Advance one clock and move the model with the inputs that were applied
  task automatic advance();
    logic redir;
    bit   timeout;
    predict();
    redir   = bus.branch | bus.jump;
    timeout = e_req && !bus.imem_ack && (m_wait + 1 == TO);
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b1; m_boot = 1'b1; m_hold = 1'b0; m_pend = 1'b0;
      m_dead = 1'b0; m_wait = 0; m_tgt = 32'h0;
    end else if (m_valid) begin
      m_wait = (e_req && !bus.imem_ack) ? m_wait + 1 : 0;
      if (m_dead) begin
        m_dead = 1'b1;
      end else if (timeout) begin
        m_dead = 1'b1; m_boot = 1'b0; m_hold = 1'b0; m_pend = 1'b0;
      end else if (m_boot) begin
        m_boot = 1'b0;
      end else if (m_hold) begin
        if (redir || !bus.stall) m_hold = 1'b0;
      end else if (m_pend) begin
        if (bus.imem_ack) m_pend = 1'b0;
        else if (redir) m_tgt = bus.jump_addr;
      end else begin
        if (bus.imem_ack && !redir && bus.stall) m_hold = 1'b1;
        if (!bus.imem_ack && redir) begin m_pend = 1'b1; m_tgt = bus.jump_addr; end
      end
    end
  endtask

  initial begin
    // reset, then zero-wait memory
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0); advance();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0); advance();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("boot_req", bus.imem_req, 32'd0);
    chk("boot_pcw", bus.pc_write, 32'd0);
    chk("boot_err", bus.fetch_err, 32'd0);
    chk("boot_addr", bus.redirect_addr, 32'h0);
    advance();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("seq_pcw", bus.pc_write, 32'd1);
      chk("seq_ifid", bus.ifid_write, 32'd1);
      chk("seq_sel", bus.pc_sel, 32'd0);
      advance();
    end

    // jump to 0x40 during a 3-cycle wait
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("w0_flush", bus.if_flush, 32'd0); advance();
    drive(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
    chk("w1_flush", bus.if_flush, 32'd1); advance();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("w2_flush", bus.if_flush, 32'd0);
    chk("w2_req", bus.imem_req, 32'd1); advance();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("drain_pcw", bus.pc_write, 32'd1);
    chk("drain_sel", bus.pc_sel, 32'd1);
    chk("drain_addr", bus.redirect_addr, 32'h40);
    chk("drain_ifid", bus.ifid_write, 32'd0);
    chk("drain_flush", bus.if_flush, 32'd1);
    advance();

    // second redirect while draining: latest target wins, stall ignored on ack
    drive(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0); advance();
    drive(1'b0, 1'b1, 1'b0, 32'h80, 1'b0, 1'b0);
    chk("drain2_flush", bus.if_flush, 32'd1); advance();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0); advance();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("drain2_addr", bus.redirect_addr, 32'h80);
    chk("drain2_pcw", bus.pc_write, 32'd1);
    chk("drain2_sel", bus.pc_sel, 32'd1);
    advance();

    // stall coincident with ack, then release
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("stall_pcw", bus.pc_write, 32'd0);
    chk("stall_ifid", bus.ifid_write, 32'd0); advance();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("hold_req", bus.imem_req, 32'd0); advance();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("hold_rel_pcw", bus.pc_write, 32'd0); advance();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("refetch_req", bus.imem_req, 32'd1);
    chk("refetch_pcw", bus.pc_write, 32'd1); advance();

    // branch beats stall in HOLD
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1); advance();
    drive(1'b0, 1'b1, 1'b0, 32'h1C, 1'b1, 1'b0);
    chk("hold_br_pcw", bus.pc_write, 32'd1);
    chk("hold_br_sel", bus.pc_sel, 32'd1);
    chk("hold_br_flush", bus.if_flush, 32'd1);
    chk("hold_br_addr", bus.redirect_addr, 32'h1C); advance();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("hold_br_req", bus.imem_req, 32'd1); advance();

    // memory never answers
    for (int i = 0; i < TO; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("to_wait_err", bus.fetch_err, 32'd0);
      chk("to_wait_req", bus.imem_req, 32'd1);
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 32'h44, 1'b0, 1'b1);
      chk("err_flag", bus.fetch_err, 32'd1);
      chk("err_req", bus.imem_req, 32'd0);
      chk("err_pcw", bus.pc_write, 32'd0);
      chk("err_flush", bus.if_flush, 32'd0);
      chk("err_addr", bus.redirect_addr, 32'h0);
      advance();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0); advance();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst_err", bus.fetch_err, 32'd0);
    chk("rst_req", bus.imem_req, 32'd0);
    advance();

    // randomized traffic, including resets mid-operation
    for (int n = 0; n < 3000; n++) begin
      logic        r_rst, r_br, r_jp, r_st, r_ak;
      logic [31:0] r_ja;
      r_rst = ($urandom_range(0, 99) < 1);
      r_br  = ($urandom_range(0, 99) < 8);
      r_jp  = ($urandom_range(0, 99) < 8);
      r_st  = ($urandom_range(0, 99) < 25);
      r_ak  = ($urandom_range(0, 99) < 60);
      r_ja  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      drive(r_rst, r_br, r_jp, r_ja, r_st, r_ak);
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
